// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: default video geometry, clear-FSM state type
// and a constant-safe clog2 used to size internal addresses.
package fb_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_PIX_W = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Never returns 0 so a degenerate one-pixel buffer still gets a 1-bit address.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port pixel RAM: one synchronous write port, one synchronous
// read-first read port. Written so synthesis maps it onto block RAM.
module fb_sdp_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: neither the array nor the read register is reset; a reset term would
  // force the array into flip-flops instead of a block RAM.
  // NOTE: non-blocking assignments make a same-edge read see the old word,
  // which is exactly the read-first behaviour the scanout relies on.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rd_data_q <= mem_q[raddr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_buffer_dp.sv
// Dual-port (x, y)-addressed frame buffer: renderer write port, scanout read
// port with a 2-cycle valid strobe, and a hardware clear sweep with busy flag.
module frame_buffer_dp
  import fb_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int PIX_W = DEF_PIX_W,
  parameter int X_W   = 10,
  parameter int Y_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr_start,
  input  logic [PIX_W-1:0] clr_value,
  output logic             busy
);

  localparam int                DEPTH     = H_RES * V_RES;
  localparam int                ADDR_W    = clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);

  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return ADDR_W'(y) * H_RES_A + ADDR_W'(x);
  endfunction

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

  clr_state_e        state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [PIX_W-1:0]  clr_value_q;

  logic              s1_wr_valid_d, s1_wr_valid_q;
  logic [ADDR_W-1:0] s1_wr_addr_d,  s1_wr_addr_q;
  logic [PIX_W-1:0]  s1_wr_data_d,  s1_wr_data_q;

  logic              s1_rd_valid_q;
  logic              s1_rd_in_range_q;
  logic [ADDR_W-1:0] s1_rd_addr_q;

  logic              rd_valid_q;
  logic              rd_zero_q;
  logic [PIX_W-1:0]  ram_rd_data;

  // Clear sweep: one word per cycle from 0 to DEPTH-1; a new start while busy is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      clr_addr_q  <= '0;
      clr_value_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            clr_addr_q  <= '0;
            clr_value_q <= clr_value;
          end
        end
        CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write mux into S1: the sweep owns the port while clearing, so external
  // writes are dropped; a write accepted with clr_start lands before the sweep.
  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    s1_wr_valid_d = wr_en && in_range(wr_x, wr_y);
    s1_wr_addr_d  = xy_to_addr(wr_x, wr_y);
    s1_wr_data_d  = wr_data;
    if (state_q == CLEAR) begin
      s1_wr_valid_d = 1'b1;
      s1_wr_addr_d  = clr_addr_q;
      s1_wr_data_d  = clr_value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_wr_valid_q <= 1'b0;
      s1_rd_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_zero_q     <= 1'b1;
    end else begin
      s1_wr_valid_q <= s1_wr_valid_d;
      s1_rd_valid_q <= rd_en;
      rd_valid_q    <= s1_rd_valid_q;
      if (s1_rd_valid_q) begin
        rd_zero_q <= !s1_rd_in_range_q;
      end
    end
  end

  // Address/data payload is qualified by the valids above, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_wr_addr_q     <= s1_wr_addr_d;
    s1_wr_data_q     <= s1_wr_data_d;
    s1_rd_addr_q     <= xy_to_addr(rd_x, rd_y);
    s1_rd_in_range_q <= in_range(rd_x, rd_y);
  end

  fb_sdp_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_ram (
    .clk       (clk),
    .we_i      (s1_wr_valid_q),
    .waddr_i   (s1_wr_addr_q),
    .wdata_i   (s1_wr_data_q),
    .re_i      (s1_rd_valid_q && s1_rd_in_range_q),
    .raddr_i   (s1_rd_addr_q),
    .rd_data_o (ram_rd_data)
  );

  // RAM output and zero flag both hold between reads, so rd_data holds too.
  assign rd_data  = rd_zero_q ? '0 : ram_rd_data;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Self-checking bench for frame_buffer_dp at 8x4 pixels, 4 bits per pixel:
// a pixel model feeds a queue of expected reads checked against rd_valid.
module tb_frame_buffer_dp;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int PW = 4;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int N  = H * V;

  typedef struct {
    logic [PW-1:0] data;
    int            cyc;
    string         tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [YW-1:0] wr_y = '0;
  logic [PW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [XW-1:0] rd_x = '0;
  logic [YW-1:0] rd_y = '0;
  logic [PW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_start = 1'b0;
  logic [PW-1:0] clr_value = '0;
  logic          busy;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [PW-1:0] model [N];
  exp_t          sb_q [$];

  frame_buffer_dp #(
    .H_RES (H),
    .V_RES (V),
    .PIX_W (PW),
    .X_W   (XW),
    .Y_W   (YW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_start (clr_start),
    .clr_value (clr_value),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every rd_valid must match the oldest outstanding read in data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_rd_valid: got rd_valid=1 data=%h at cycle %0d, required no read outstanding",
                 rd_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (rd_data !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL %s: got data=%h at cycle %0d, required data=%h at cycle %0d",
                   e.tag, rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

  // One clock of stimulus; a read sees the model before this cycle's write (read-first).
  task automatic cycle_io(input bit we, input int wx, input int wy, input logic [PW-1:0] wd,
                          input bit re, input int rx, input int ry, input string tag);
    exp_t e;
    if (re) begin
      e.data = (rx < H && ry < V) ? model[ry*H + rx] : '0;
      e.cyc  = cyc + 2;
      e.tag  = tag;
      sb_q.push_back(e);
    end
    if (we && wx < H && wy < V) model[wy*H + wx] = wd;
    wr_en   = we;
    wr_x    = XW'(wx);
    wr_y    = YW'(wy);
    wr_data = wd;
    rd_en   = re;
    rd_x    = XW'(rx);
    rd_y    = YW'(ry);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_io(0, 0, 0, '0, 0, 0, 0, "");
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d reads still outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rd_valid: got %b, required 0", rd_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    n_cmp++;
    if (rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_rd_data: got %h, required 0", rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    cycle_io(1, 3, 2, 4'hA, 0, 0, 0, "");
    idle(1);
    cycle_io(0, 0, 0, '0, 1, 3, 2, "write_read_3_2");
    drain("write_read");
  endtask

  task automatic test_streaming();
    for (int a = 0; a < N; a++) cycle_io(1, a % H, a / H, PW'(a % H + a / H), 0, 0, 0, "");
    for (int a = 0; a < N; a++) cycle_io(0, 0, 0, '0, 1, a % H, a / H, "stream_read");
    drain("stream");
    idle(2);
    n_cmp++;
    if (rd_data !== model[N-1] || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_hold: got data=%h valid=%b, required data=%h valid=0",
               rd_data, rd_valid, model[N-1]);
    end
  endtask

  task automatic test_out_of_range();
    cycle_io(1, 8, 0, 4'hF, 0, 0, 0, "");
    cycle_io(1, 0, 4, 4'hF, 0, 0, 0, "");
    idle(1);
    cycle_io(0, 0, 0, '0, 1, 0, 1, "oor_keep_0_1");
    cycle_io(0, 0, 0, '0, 1, 0, 0, "oor_keep_0_0");
    cycle_io(0, 0, 0, '0, 1, 8, 0, "oor_read_8_0");
    cycle_io(0, 0, 0, '0, 1, 3, 9, "oor_read_3_9");
    drain("out_of_range");
  endtask

  task automatic test_collision();
    cycle_io(1, 2, 1, 4'h3, 0, 0, 0, "");
    idle(1);
    cycle_io(1, 2, 1, 4'hC, 1, 2, 1, "collision_old");
    cycle_io(0, 0, 0, '0, 1, 2, 1, "collision_new");
    drain("collision");
  endtask

  task automatic test_clear();
    int cnt;
    int guard;
    clr_value = 4'h5;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    cnt   = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      if (cnt == 3) begin
        wr_en = 1'b1; wr_x = XW'(1); wr_y = YW'(1); wr_data = 4'h9;
      end
      if (cnt == 5) begin
        clr_start = 1'b1; clr_value = 4'hE;
      end
      @(negedge clk);
      wr_en = 1'b0;
      clr_start = 1'b0;
      cnt++;
      guard++;
    end
    n_cmp++;
    if (cnt != N) begin
      n_err++;
      $display("FAIL clear_busy_cycles: got %0d, required %0d", cnt, N);
    end
    for (int a = 0; a < N; a++) model[a] = 4'h5;
    for (int a = 0; a < N; a++) cycle_io(0, 0, 0, '0, 1, a % H, a / H, "clear_fill");
    drain("clear");
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < N; a++) cycle_io(1, a % H, a / H, PW'((a * 3 + 1) % 16), 0, 0, 0, "");
    idle(1);
    clr_value = 4'h7;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL rmc_busy_%0d: got %b, required 1", i, busy);
      end
      if (i == 9) begin
        rd_en = 1'b1; rd_x = '0; rd_y = '0;
      end
      @(negedge clk);
      rd_en = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmc_after_reset: got busy=%b rd_valid=%b, required busy=0 rd_valid=0",
               busy, rd_valid);
    end
    rst = 1'b0;
    for (int a = 0; a < 10; a++) model[a] = 4'h7;
    for (int a = 0; a < N; a++) cycle_io(0, 0, 0, '0, 1, a % H, a / H, "rmc_read");
    drain("reset_mid_clear");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_streaming();
    test_out_of_range();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
